// File: rtl/ones_stuff_pkg.sv
// Shared types and default constants for the ones-stuffing serial transmitter.
package ones_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STUFF,
        FLAG
    } ones_stuff_state_t;

    localparam int ONES_STUFF_DATA_W  = 8;
    localparam int ONES_STUFF_MAX_RUN = 2;

endpackage

// File: rtl/ones_run_cnt.sv
// Saturating count of consecutive transmitted ones; at_max flags the one that completes a run.
module ones_run_cnt #(
    parameter int MAX_RUN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic en,
    input  logic clr,
    output logic at_max
);

    localparam int RW = $clog2(MAX_RUN + 1);

    logic [RW-1:0] run_q, run_d;

    always_comb begin
        run_d = run_q;
        if (clr) begin
            run_d = '0;
        end else if (en) begin
            if (!bit_in)
                run_d = '0;
            else if (run_q != RW'(MAX_RUN))
                run_d = run_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            run_q <= '0;
        else
            run_q <= run_d;
    end

    // Combinational so the FSM can branch to STUFF on the very bit that hits the limit.
    assign at_max = en && bit_in && (run_q == RW'(MAX_RUN - 1));

endmodule

// File: rtl/ones_stuff_tx.sv
// MSB-first serial transmitter that stuffs a 0 after every MAX_RUN data ones.
// Define ONES_STUFF_TX_FLAG_EN to add the flag_req/flag_ack marker generator.
module ones_stuff_tx
    import ones_stuff_pkg::*;
#(
    parameter int DATA_W  = ONES_STUFF_DATA_W,
    parameter int MAX_RUN = ONES_STUFF_MAX_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    output logic              busy
`ifdef ONES_STUFF_TX_FLAG_EN
    ,
    input  logic              flag_req,
    output logic              flag_ack
`endif
);

    localparam int CW = $clog2(DATA_W + 1);

    ones_stuff_state_t state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              x_valid_q, x_valid_d;
    logic              run_at_max;

`ifdef ONES_STUFF_TX_FLAG_EN
    localparam int FLEN = MAX_RUN + 3;
    localparam int FW   = $clog2(FLEN);
    logic [FW-1:0] fpos_q, fpos_d;
`endif

    ones_run_cnt #(.MAX_RUN(MAX_RUN)) u_run (
        .clk    (clk),
        .rst    (rst),
        .bit_in (sreg_q[DATA_W-1]),
        .en     (state_q == SHIFT),
        .clr    (state_q != SHIFT),
        .at_max (run_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
`ifdef ONES_STUFF_TX_FLAG_EN
            fpos_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
`ifdef ONES_STUFF_TX_FLAG_EN
            fpos_q    <= fpos_d;
`endif
        end
    end

    // state_q names the bit on the line this cycle; cnt_q counts data bits left including it.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef ONES_STUFF_TX_FLAG_EN
        fpos_d  = fpos_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ONES_STUFF_TX_FLAG_EN
                if (flag_req) begin
                    state_d = FLAG;
                    fpos_d  = '0;
                end else
`endif
                if (din_valid) begin
                    state_d = SHIFT;
                    sreg_d  = din;
                    cnt_d   = CW'(DATA_W);
                end
            end
            SHIFT: begin
                sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (run_at_max)
                    state_d = STUFF;
                else if (cnt_q == CW'(1))
                    state_d = IDLE;
            end
            STUFF: begin
                state_d = (cnt_q != '0) ? SHIFT : IDLE;
            end
`ifdef ONES_STUFF_TX_FLAG_EN
            FLAG: begin
                if (fpos_q == FW'(FLEN - 1))
                    state_d = IDLE;
                else
                    fpos_d = fpos_q + FW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output bit is registered, so it is derived from the state being entered.
    always_comb begin
        x_d       = 1'b0;
        x_valid_d = (state_d != IDLE);
        case (state_d)
            SHIFT: x_d = sreg_d[DATA_W-1];
`ifdef ONES_STUFF_TX_FLAG_EN
            FLAG:  x_d = (fpos_d != '0) && (fpos_d != FW'(FLEN - 1));
`endif
            default: x_d = 1'b0;
        endcase
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign busy      = (state_q != IDLE);
    assign din_ready = (state_q == IDLE);
`ifdef ONES_STUFF_TX_FLAG_EN
    assign flag_ack  = !rst && (state_q == IDLE) && flag_req;
`endif

endmodule

// File: doc/ones_stuff_tx.md
# ones_stuff_tx

Serial transmitter that feeds the consecutive-ones detector. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first on a single serial line `x`. After every run of `MAX_RUN` data ones it inserts a zero, so the downstream three-ones checker never fires on payload data. An optional flag generator emits a deliberate `MAX_RUN+1`-ones marker that the checker is meant to detect.

## Interface
- `DATA_W`, default 8: width of parallel input word; must be ≥ 2.
- `MAX_RUN`, default 2: maximum consecutive data ones before a stuffed 0; must be ≥ 1.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  DATA_W: word to transmit; sampled when `din_valid && din_ready`.
- `din_valid`  in  1: `din` holds a word.
- `din_ready`  out  1: block can accept a word; high only in IDLE.
- `x`  out  1: serial bit, registered; 0 whenever `x_valid` = 0.
- `x_valid`  out  1: `x` carries a data, stuff or flag bit this cycle.
- `busy`  out  1: FSM not in IDLE.
- `flag_req`  in  1: present only with `ONES_STUFF_TX_FLAG_EN`; request a flag.
- `flag_ack`  out  1: present only with `ONES_STUFF_TX_FLAG_EN`; one-cycle pulse when a flag request is accepted.

## Operation
- Reset values:
  - `x` = 0, `x_valid` = 0, `busy` = 0, `din_ready` = 1, `flag_ack` = 0.
  - State = IDLE; run counter = 0; bit counter = 0.
- States: IDLE, SHIFT, STUFF, plus FLAG when the macro is defined.
- IDLE:
  - `din_ready` = 1.
  - On `din_valid`, load the shift register and set the bit counter to `DATA_W`, then go to SHIFT.
  - Run counter is cleared, because the idle line drives 0.
- SHIFT:
  - Each cycle, drive the shift-register MSB on `x` with `x_valid` = 1, shift left, and decrement the bit counter.
  - Run counter: a 1 increments it; a 0 clears it.
  - If the emitted bit is 1 and the run reaches `MAX_RUN`, go to STUFF. This takes priority even on the last data bit.
  - Otherwise, on the last bit go to IDLE; else stay in SHIFT.
- STUFF:
  - Emit one `x` = 0 with `x_valid` = 1 and clear the run counter.
  - Return to SHIFT if bits remain, else go to IDLE.
- The run counter never exceeds `MAX_RUN`, so the output never contains `MAX_RUN+1` consecutive ones outside a flag.
- Words are not streamed back-to-back. At least one idle cycle (`x` = 0, `x_valid` = 0) separates transmissions, and that cycle resets the run.
- `din_valid` held high while `busy` is ignored; the word stays pending until the next IDLE.
- `rst` mid-transmission aborts the word. No partial stuffing is emitted.
- Width rules:
  - Bit counter is `$clog2(DATA_W+1)` bits.
  - Run counter is `$clog2(MAX_RUN+1)` bits.
  - Transmitted frame length is `DATA_W` + (number of stuff bits), up to `DATA_W + DATA_W/MAX_RUN`.

## Timing
- Handshake accepted in cycle N (edge at end of N); first bit on `x` in cycle N+1.
- Frame bits occupy consecutive cycles with no gaps.
- Cycle after the last frame bit: `x_valid` = 0 and `din_ready` = 1. The next word is accepted at the earliest in that cycle.
- `rst` sampled high at edge E: the outputs take their reset values from E onward.

## Configuration
- `ONES_STUFF_TX_FLAG_EN` defined:
  - Adds the `flag_req`/`flag_ack` ports and the FLAG state.
  - In IDLE, `flag_req` has priority over `din_valid`; `flag_ack` pulses in the accepting cycle.
  - FLAG emits 0, then `MAX_RUN+1` ones, then 0, all with `x_valid` = 1, then returns to IDLE.
  - Run stuffing is suppressed inside FLAG.
- Undefined: no flag ports, no FLAG state. The output never contains `MAX_RUN+1` consecutive ones.

## Structure
- Package `ones_stuff_pkg` holds:
  - the state enum `ones_stuff_state_t` (IDLE, SHIFT, STUFF, FLAG);
  - the default constants `ONES_STUFF_DATA_W` = 8 and `ONES_STUFF_MAX_RUN` = 2.
- One sub-module, `ones_run_cnt`: a saturating run counter with inputs `bit`, `en` and `clr`, and output `at_max`. The transmitter instantiates it once.

## Test plan
(`DATA_W` = 8, `MAX_RUN` = 2)
- Hold `rst` 2 cycles → `x` = 0, `x_valid` = 0, `busy` = 0, `din_ready` = 1; `din_valid` during reset is not captured.
- `din` = 8'hA5 → `x` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8 with `x_valid` high; no stuff; `din_ready` low N+1..N+8 and high at N+9.
- `din` = 8'h6E → `x` = 0,1,1,0*,0,1,1,0*,1,0 (10 bits; * marks stuffed bits).
- `din` = 8'hFF → `x` = 1,1,0,1,1,0,1,1,0,1,1,0 (12 bits, including a trailing stuff bit). Feeding the three-ones checker, its `z` stays 0 throughout.
- `din` = 8'hFF, assert `rst` on the 4th frame bit → next cycle `x_valid` = 0 and `din_ready` = 1. A following `din` = 8'h01 sends 0,0,0,0,0,0,0,1 cleanly.
- With `ONES_STUFF_TX_FLAG_EN`, `flag_req` and `din_valid` high in the same IDLE cycle:
  - `flag_ack` pulses and `x` = 0,1,1,1,0.
  - The checker's `z` = 1 on the third 1.
  - The pending word is then accepted after one idle cycle.
